// File: rtl/risc_dmem_arbiter.sv
// risc_dmem_arbiter
//   Shares one single-port data memory between the CPU execution unit and a
//   loader/debug port. Each requester uses a req/gnt handshake. The granted
//   command is registered onto the memory-side outputs one cycle later. Read
//   data is steered back to its owner through a {valid, owner} tag pipeline.
//   The CPU has priority. A starvation counter forces a loader grant after
//   STARVE consecutive CPU wins. A lock mode gives the loader exclusive
//   access for burst loading.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   cpu_req/rdwr/addr/wdata   CPU command (rdwr: 1=read, 0=write)
//   cpu_gnt                   CPU command accepted this cycle (combinational)
//   cpu_rvalid/rdata          CPU read return (registered)
//   ldr_req/lock/rdwr/addr/wdata  loader command plus exclusive-bus request
//   ldr_gnt                   loader command accepted this cycle (combinational)
//   ldr_rvalid/rdata          loader read return (registered)
//   dmenbl/rdwr/dmaddr/dmdatain   registered memory command
//   dmdataout                 memory read data, valid RD_LAT cycles after issue

module risc_dmem_arbiter #(
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_rdwr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          ldr_req,
    input  logic          ldr_lock,
    input  logic          ldr_rdwr,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,

    output logic          dmenbl,
    output logic          rdwr,
    output logic [AW-1:0] dmaddr,
    output logic [DW-1:0] dmdatain,
    input  logic [DW-1:0] dmdataout
);

    localparam int unsigned CW = $clog2(STARVE + 1);

    typedef enum logic {StArb, StLock} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_starve;

    logic                r_dmenbl;
    logic                r_rdwr;
    logic [AW-1:0]       r_dmaddr;
    logic [DW-1:0]       r_dmdatain;
    // Owner of the command currently on the memory outputs (1 = loader).
    logic                r_iss_owner;

    logic [RD_LAT-1:0]   r_tag_v;
    logic [RD_LAT-1:0]   r_tag_o;

    logic                r_cpu_rvalid;
    logic [DW-1:0]       r_cpu_rdata;
    logic                r_ldr_rvalid;
    logic [DW-1:0]       r_ldr_rdata;

    logic                w_lock_hold;
    logic                w_cpu_gnt;
    logic                w_ldr_gnt;
    logic                w_xfer;
    logic                w_ret_v;
    logic                w_ret_o;

    // Lock is dropped combinationally: once ldr_lock falls, this cycle
    // already arbitrates normally.
    always_comb begin
        w_lock_hold = (r_state == StLock) && ldr_lock;
        w_cpu_gnt   = 1'b0;
        w_ldr_gnt   = 1'b0;
        if (!rst) begin
            if (w_lock_hold) begin
                w_ldr_gnt = ldr_req;
            end else if (ldr_req && (r_starve == CW'(STARVE))) begin
                w_ldr_gnt = 1'b1;
            end else if (cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (ldr_req) begin
                w_ldr_gnt = 1'b1;
            end
        end
        w_xfer  = w_cpu_gnt | w_ldr_gnt;
        w_ret_v = r_tag_v[RD_LAT-1];
        w_ret_o = r_tag_o[RD_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StArb;
            r_starve     <= '0;
            r_dmenbl     <= 1'b0;
            r_rdwr       <= 1'b1;
            r_dmaddr     <= '0;
            r_dmdatain   <= '0;
            r_iss_owner  <= 1'b0;
            r_tag_v      <= '0;
            r_tag_o      <= '0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ldr_rvalid <= 1'b0;
            r_ldr_rdata  <= '0;
        end else begin
            // State machine: enter LOCK on a locked loader transfer, stay
            // while lock is held, otherwise fall back to ARB.
            if (w_ldr_gnt && ldr_lock) begin
                r_state <= StLock;
            end else if (!w_lock_hold) begin
                r_state <= StArb;
            end

            // Starvation counter: counts CPU wins while the loader waits.
            if (w_ldr_gnt || !ldr_req) begin
                r_starve <= '0;
            end else if (w_cpu_gnt && (r_starve != CW'(STARVE))) begin
                r_starve <= r_starve + CW'(1);
            end

            // Memory command issue. Idle cycles only drop the enable.
            r_dmenbl <= w_xfer;
            if (w_xfer) begin
                r_iss_owner <= w_ldr_gnt;
                if (w_ldr_gnt) begin
                    r_rdwr     <= ldr_rdwr;
                    r_dmaddr   <= ldr_addr;
                    r_dmdatain <= ldr_wdata;
                end else begin
                    r_rdwr     <= cpu_rdwr;
                    r_dmaddr   <= cpu_addr;
                    r_dmdatain <= cpu_wdata;
                end
            end

            // Tag pipeline: stage 0 is loaded from the command on the memory
            // outputs, so the last stage lines up with dmdataout.
            r_tag_v[0] <= r_dmenbl & r_rdwr;
            r_tag_o[0] <= r_iss_owner;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_o[i] <= r_tag_o[i-1];
            end

            // Read return to the owning requester.
            r_cpu_rvalid <= w_ret_v & ~w_ret_o;
            r_ldr_rvalid <= w_ret_v & w_ret_o;
            if (w_ret_v && !w_ret_o) begin
                r_cpu_rdata <= dmdataout;
            end
            if (w_ret_v && w_ret_o) begin
                r_ldr_rdata <= dmdataout;
            end
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign ldr_gnt    = w_ldr_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign ldr_rvalid = r_ldr_rvalid;
    assign ldr_rdata  = r_ldr_rdata;
    assign dmenbl     = r_dmenbl;
    assign rdwr       = r_rdwr;
    assign dmaddr     = r_dmaddr;
    assign dmdatain   = r_dmdatain;

endmodule

// File: tb/tb_risc_dmem_arbiter.sv
// tb_risc_dmem_arbiter
//   Directed bench for risc_dmem_arbiter with a 16x8 memory model of
//   read latency 1. Inputs change 1 ns after the rising edge. Outputs are
//   sampled mid-cycle.

module tb_risc_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_rdwr;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       ldr_req, ldr_lock, ldr_rdwr;
    logic [3:0] ldr_addr;
    logic [7:0] ldr_wdata;
    logic       ldr_gnt, ldr_rvalid;
    logic [7:0] ldr_rdata;
    logic       dmenbl, rdwr;
    logic [3:0] dmaddr;
    logic [7:0] dmdatain;
    logic [7:0] dmdataout;

    logic [7:0] mem [16];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    risc_dmem_arbiter #(
        .AW     (4),
        .DW     (8),
        .RD_LAT (1),
        .STARVE (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_rdwr   (cpu_rdwr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_lock   (ldr_lock),
        .ldr_rdwr   (ldr_rdwr),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .dmenbl     (dmenbl),
        .rdwr       (rdwr),
        .dmaddr     (dmaddr),
        .dmdatain   (dmdatain),
        .dmdataout  (dmdataout)
    );

    // Memory model: data is registered one cycle after the command cycle.
    // Contents are preloaded while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem[3]    <= 8'hA5;
            dmdataout <= 8'h00;
        end else if (dmenbl) begin
            if (rdwr) dmdataout <= mem[dmaddr];
            else      mem[dmaddr] <= dmdatain;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_rdwr = 1'b1; cpu_addr = 4'h0; cpu_wdata = 8'h00;
        ldr_req = 1'b0; ldr_lock = 1'b0; ldr_rdwr = 1'b1; ldr_addr = 4'h0;
        ldr_wdata = 8'h00;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset and idle. Grants stay low during reset even with a request.
        cpu_req = 1'b1;
        #1; mid();
        check_eq("rst_cpu_gnt", 32'(cpu_gnt), 0);
        tick(); mid();
        check_eq("rst_cpu_gnt2", 32'(cpu_gnt), 0);
        tick();
        rst = 1'b0;
        idle_inputs();
        mid();
        check_eq("rst_dmenbl", 32'(dmenbl), 0);
        check_eq("rst_rdwr", 32'(rdwr), 1);
        check_eq("rst_dmaddr", 32'(dmaddr), 0);
        check_eq("rst_dmdatain", 32'(dmdatain), 0);
        check_eq("rst_rvalid", 32'({cpu_rvalid, ldr_rvalid}), 0);
        check_eq("rst_rdata", 32'({cpu_rdata, ldr_rdata}), 0);
        for (int i = 0; i < 10; i++) begin
            tick(); mid();
            check_eq("idle_dmenbl", 32'(dmenbl), 0);
        end

        // CPU read of address 3, memory holds A5.
        tick();
        cpu_req = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 4'h3;
        mid();
        check_eq("rd_cpu_gnt", 32'({cpu_gnt, ldr_gnt}), 32'b10);
        tick();
        cpu_req = 1'b0;
        mid();
        check_eq("rd_issue", 32'({dmenbl, rdwr, dmaddr}), 32'b1_1_0011);
        check_eq("rd_early_rvalid", 32'(cpu_rvalid), 0);
        tick(); mid();
        check_eq("rd_idle_dmenbl", 32'(dmenbl), 0);
        tick(); mid();
        check_eq("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
        check_eq("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        check_eq("rd_ldr_rvalid", 32'(ldr_rvalid), 0);
        tick(); mid();
        check_eq("rd_rvalid_pulse", 32'(cpu_rvalid), 0);
        check_eq("rd_rdata_hold", 32'(cpu_rdata), 32'hA5);

        // Contention: both requesters always pending, pattern C,C,C,C,L.
        tick();
        cpu_req = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 4'h0;
        ldr_req = 1'b1; ldr_rdwr = 1'b1; ldr_addr = 4'h0;
        for (int k = 0; k < 10; k++) begin
            mid();
            if (k % 5 == 4) check_eq("starve_ldr", 32'({cpu_gnt, ldr_gnt}), 32'b01);
            else            check_eq("starve_cpu", 32'({cpu_gnt, ldr_gnt}), 32'b10);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        // Lock burst: loader writes C0..C7 to addresses 0..7.
        ldr_req = 1'b1; ldr_lock = 1'b1; ldr_rdwr = 1'b0;
        ldr_addr = 4'h0; ldr_wdata = 8'hC0;
        mid();
        check_eq("lock_first_gnt", 32'({cpu_gnt, ldr_gnt}), 32'b01);
        for (int i = 1; i < 8; i++) begin
            tick();
            cpu_req = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 4'h5;
            ldr_addr = 4'(i); ldr_wdata = 8'hC0 + 8'(i);
            mid();
            check_eq("lock_gnt", 32'({cpu_gnt, ldr_gnt}), 32'b01);
            check_eq("lock_issue", 32'({dmenbl, rdwr, dmaddr, dmdatain}),
                     32'({1'b1, 1'b0, 4'(i - 1), 8'hC0 + 8'(i - 1)}));
        end
        tick();
        ldr_lock = 1'b0; ldr_addr = 4'h8; ldr_wdata = 8'hC8;
        mid();
        check_eq("unlock_cpu_gnt", 32'({cpu_gnt, ldr_gnt}), 32'b10);
        check_eq("unlock_last_data", 32'(dmdatain), 32'hC7);
        tick();
        cpu_req = 1'b0;
        mid();
        check_eq("unlock_ldr_gnt", 32'({cpu_gnt, ldr_gnt}), 32'b01);
        check_eq("unlock_cpu_issue", 32'({dmenbl, rdwr, dmaddr}), 32'b1_1_0101);
        tick();
        idle_inputs();
        tick(); mid();
        check_eq("lock_cpu_rvalid", 32'(cpu_rvalid), 1);
        check_eq("lock_cpu_rdata", 32'(cpu_rdata), 32'hC5);
        repeat (3) tick();

        // Ordered returns: cpu@1, ldr@2, cpu@3 back-to-back.
        cpu_req = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 4'h1;
        mid();
        check_eq("ord_g0", 32'({cpu_gnt, ldr_gnt}), 32'b10);
        tick();
        cpu_req = 1'b0;
        ldr_req = 1'b1; ldr_rdwr = 1'b1; ldr_addr = 4'h2;
        mid();
        check_eq("ord_g1", 32'({cpu_gnt, ldr_gnt}), 32'b01);
        tick();
        ldr_req = 1'b0;
        cpu_req = 1'b1; cpu_addr = 4'h3;
        mid();
        check_eq("ord_g2", 32'({cpu_gnt, ldr_gnt}), 32'b10);
        tick();
        idle_inputs();
        mid();
        check_eq("ord_c3_rv", 32'({cpu_rvalid, ldr_rvalid}), 32'b10);
        check_eq("ord_c3_rd", 32'(cpu_rdata), 32'hC1);
        tick(); mid();
        check_eq("ord_c4_rv", 32'({cpu_rvalid, ldr_rvalid}), 32'b01);
        check_eq("ord_c4_rd", 32'(ldr_rdata), 32'hC2);
        tick(); mid();
        check_eq("ord_c5_rv", 32'({cpu_rvalid, ldr_rvalid}), 32'b10);
        check_eq("ord_c5_rd", 32'(cpu_rdata), 32'hC3);
        tick(); mid();
        check_eq("ord_c6_rv", 32'({cpu_rvalid, ldr_rvalid}), 32'b00);
        check_eq("ord_ldr_hold", 32'(ldr_rdata), 32'hC2);
        repeat (2) tick();

        // Reset mid-read: the discarded read must never return.
        cpu_req = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 4'h3;
        mid();
        check_eq("mr_gnt", 32'(cpu_gnt), 1);
        tick();
        cpu_req = 1'b0; rst = 1'b1;
        mid();
        check_eq("mr_issue", 32'({dmenbl, dmaddr}), 32'b1_0011);
        tick();
        rst = 1'b0;
        mid();
        check_eq("mr_rst_outs", 32'({dmenbl, rdwr, dmaddr, dmdatain}), 32'b0_1_0000_00000000);
        check_eq("mr_rst_rdata", 32'({cpu_rdata, ldr_rdata}), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); mid();
            check_eq("mr_no_rvalid", 32'({cpu_rvalid, ldr_rvalid}), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/risc_dmem_arbiter.md
Name: risc_dmem_arbiter

Overview:
- Shares the single-port data memory (4-bit address, 8-bit data) between the CPU execution unit and a memory loader/debug port.
- Uses a per-requester req/gnt handshake and issues one memory command per cycle through registered memory-side outputs.
- Read data returns to the owning requester, tagged through a read-latency pipeline.
- CPU has priority, with a starvation counter and a loader lock mode for burst loading.

Parameters:
AW, 4, address width
DW, 8, data width
RD_LAT, 1, memory read latency in cycles from command cycle to dmdataout valid (1..4)
STARVE, 4, maximum consecutive CPU grants while loader is pending before the loader is forced a grant

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request
cpu_rdwr  in  1  CPU command: 1=read, 0=write
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU command accepted this cycle (combinational)
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DW  CPU read data
ldr_req  in  1  loader access request
ldr_lock  in  1  loader requests exclusive bus (sampled with ldr_req)
ldr_rdwr  in  1  loader command: 1=read, 0=write
ldr_addr  in  AW  loader address
ldr_wdata  in  DW  loader write data
ldr_gnt  out  1  loader command accepted this cycle (combinational)
ldr_rvalid  out  1  loader read data valid
ldr_rdata  out  DW  loader read data
dmenbl  out  1  memory enable (registered)
rdwr  out  1  memory command, 1=read, 0=write (registered)
dmaddr  out  AW  memory address (registered)
dmdatain  out  DW  write data to memory (registered)
dmdataout  in  DW  read data from memory

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Handshake:
  - A transfer occurs on a rising edge where req&gnt=1. At most one gnt is high per cycle.
  - A requester holds req and its command stable until it sees gnt.
  - gnt never asserts without req.
- Issue: the granted command is registered onto dmenbl/rdwr/dmaddr/dmdatain in the next cycle (T+1). dmenbl=0 in any cycle following a cycle with no transfer; the other memory outputs then hold their previous values.
- Read return:
  - A read issued in cycle T+1 is presented on dmdataout at T+1+RD_LAT.
  - The arbiter carries a {valid, owner} tag through an RD_LAT-deep shift register.
  - At the matching cycle it asserts the owner's rvalid for exactly 1 cycle and registers dmdataout into the owner's rdata; rvalid is therefore seen at T+2+RD_LAT.
  - rdata holds its value until the next return.
  - Writes produce no rvalid. Back-to-back reads give back-to-back rvalids in issue order.
- State machine ARB / LOCK:
  - ARB, arbitration order:
    - If ldr_req and starve_cnt==STARVE, grant the loader.
    - Else if cpu_req, grant the CPU.
    - Else if ldr_req, grant the loader.
  - starve_cnt behaviour:
    - Increments, saturating at STARVE, on each CPU grant while ldr_req=1.
    - Clears on any loader grant, or when ldr_req=0.
  - ARB -> LOCK on a loader transfer with ldr_lock=1.
  - LOCK: only the loader is granted (ldr_gnt=ldr_req); cpu_gnt=0.
  - LOCK -> ARB on the first cycle with ldr_lock=0, evaluated combinationally, so normal arbitration already applies in that cycle.
  - In-flight reads complete normally across state changes.
- Simultaneous events: a write and a read to the same address in consecutive cycles are issued in grant order. No forwarding; memory ordering applies.
- Reset:
  - dmenbl=0, rdwr=1, dmaddr=0, dmdatain=0.
  - cpu_gnt=ldr_gnt=0 while rst=1.
  - cpu_rvalid=ldr_rvalid=0, cpu_rdata=ldr_rdata=0.
  - State=ARB, starve_cnt=0, tag pipeline cleared.
  - Reset mid-operation discards in-flight reads: no rvalid is ever produced for a read issued before reset.

Test Plan:
- Reset/idle: hold rst 2 cycles, then no requests -> all outputs at reset values, dmenbl stays 0 for 10 cycles.
- CPU read, RD_LAT=1: cpu_req, rdwr=1, addr=4'h3 at cycle 0; memory returns 8'hA5 -> cpu_gnt at 0; dmenbl=1, rdwr=1, dmaddr=3 at cycle 1; cpu_rvalid=1, cpu_rdata=8'hA5 at cycle 3; ldr_rvalid stays 0.
- Contention/starvation, STARVE=4: cpu_req and ldr_req held high continuously -> grant pattern C,C,C,C,L repeating; ldr_gnt never absent more than 4 consecutive cycles.
- Lock burst: loader writes addr 0..7 with ldr_lock=1 while cpu_req=1 -> 8 consecutive ldr_gnt with cpu_gnt=0; dmdatain follows the loader data. The first cycle with ldr_lock=0 and both requesters pending grants the CPU.
- Ordered returns: CPU read addr 1, loader read addr 2, CPU read addr 3 back-to-back -> rvalids in issue order (cpu, ldr, cpu) with rdata matching memory contents 1, 2, 3.
- Reset mid-read: issue a CPU read, assert rst in the following cycle -> no cpu_rvalid for that read; outputs return to reset values.
